// File: rtl/keen_pkg.sv
// ----------------------------------------------------------------------------
// keen_pkg
// Shared definitions for the fetch-stage program-counter logic.
//   - pc_state_e  : PC unit state (BOOT, RUN, FAULT), PC_STATE_W bits wide
//   - ialign_bytes: instruction alignment in bytes, shared with decode
// Configuration macro: KEEN_PC_COMPRESSED_EN (compressed-instruction support,
// which relaxes the alignment to 2 bytes).
// ----------------------------------------------------------------------------
package keen_pkg;

    localparam int PC_STATE_W = 2;

`ifdef KEEN_PC_COMPRESSED_EN
    localparam bit COMPRESSED_EN = 1'b1;
`else
    localparam bit COMPRESSED_EN = 1'b0;
`endif

    typedef enum logic [PC_STATE_W-1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        FAULT = 2'd2
    } pc_state_e;

    // With compressed instructions any 2-byte boundary is a legal target;
    // otherwise targets must sit on a full instruction boundary.
    function automatic int ialign_bytes(input int ilen);
        return COMPRESSED_EN ? 2 : ilen / 8;
    endfunction

endpackage

// File: rtl/keen_pc_next.sv
// ----------------------------------------------------------------------------
// keen_pc_next
// Combinational next-pc selection for the PC unit.
// Priority in RUN: trap > aligned branch > misaligned branch (hold) >
// sequential advance > stall. In FAULT only a trap moves the pc.
// Ports:
//   state           current PC unit state
//   pc              current pc
//   pc_ready        fetch port accepts pc this cycle
//   branch          branch/jump redirect request
//   branch_address  branch target
//   trap            trap redirect request
//   trap_vector     trap handler address (low alignment bits are dropped)
//   inst_compressed (KEEN_PC_COMPRESSED_EN only) advance by 2 bytes
//   next_pc         pc value for the next cycle
//   take_redirect   a trap or branch redirect is taken this cycle
//   misaligned      a misaligned branch is being turned into a fault
// ----------------------------------------------------------------------------
module keen_pc_next
    import keen_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int ILEN = 32
) (
    input  pc_state_e        state,
    input  logic [XLEN-1:0]  pc,
    input  logic             pc_ready,
    input  logic             branch,
    input  logic [XLEN-1:0]  branch_address,
    input  logic             trap,
    input  logic [XLEN-1:0]  trap_vector,
`ifdef KEEN_PC_COMPRESSED_EN
    input  logic             inst_compressed,
`endif
    output logic [XLEN-1:0]  next_pc,
    output logic             take_redirect,
    output logic             misaligned
);

    localparam int              IALIGN     = ialign_bytes(ILEN);
    localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'(IALIGN - 1);
    localparam logic [XLEN-1:0] FULL_STEP  = XLEN'(ILEN / 8);

    logic [XLEN-1:0] step;
    logic [XLEN-1:0] trap_target;
    logic            target_misaligned;

    // Sequential increment: a compressed instruction only occupies two bytes.
`ifdef KEEN_PC_COMPRESSED_EN
    assign step = inst_compressed ? XLEN'(2) : FULL_STEP;
`else
    assign step = FULL_STEP;
`endif

    // Trap handlers are forced onto a legal boundary rather than faulting.
    assign trap_target       = trap_vector & ~ALIGN_MASK;
    assign target_misaligned = |(branch_address & ALIGN_MASK);

    // Priority mux. A redirect never waits for pc_ready; an unaccepted fetch
    // is simply dropped and the fetch side flushes it.
    always_comb begin
        next_pc       = pc;
        take_redirect = 1'b0;
        misaligned    = 1'b0;
        case (state)
            RUN: begin
                if (trap) begin
                    next_pc       = trap_target;
                    take_redirect = 1'b1;
                end else if (branch && !target_misaligned) begin
                    next_pc       = branch_address;
                    take_redirect = 1'b1;
                end else if (branch) begin
                    misaligned    = 1'b1;
                end else if (pc_ready) begin
                    next_pc       = pc + step;
                end
            end
            FAULT: begin
                if (trap) begin
                    next_pc       = trap_target;
                    take_redirect = 1'b1;
                end
            end
            default: begin
                next_pc = pc;
            end
        endcase
    end

endmodule

// File: rtl/keen_pc_unit.sv
// ----------------------------------------------------------------------------
// keen_pc_unit
// Program-counter unit for the fetch stage: boot cycle, valid/ready fetch
// handshake, trap/branch redirects and misaligned-branch fault handling.
// Ports:
//   clk, reset      clock and synchronous active-high reset
//   pc_ready        fetch port accepts the current pc
//   branch          branch redirect request, target in branch_address
//   trap            trap redirect request, target in trap_vector
//   inst_compressed (KEEN_PC_COMPRESSED_EN only) current instruction is 16-bit
//   pc, pc_valid    fetch request
//   fault_valid     one-cycle pulse on a misaligned branch target
//   fault_address   offending target, held until the next fault
// Configuration macro: KEEN_PC_COMPRESSED_EN.
// ----------------------------------------------------------------------------
module keen_pc_unit
    import keen_pkg::*;
#(
    parameter int              XLEN         = 32,
    parameter int              ILEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = 32'h8000_0000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             pc_ready,
    input  logic             branch,
    input  logic [XLEN-1:0]  branch_address,
    input  logic             trap,
    input  logic [XLEN-1:0]  trap_vector,
`ifdef KEEN_PC_COMPRESSED_EN
    input  logic             inst_compressed,
`endif
    output logic [XLEN-1:0]  pc,
    output logic             pc_valid,
    output logic             fault_valid,
    output logic [XLEN-1:0]  fault_address
);

    pc_state_e       state;
    logic [XLEN-1:0] next_pc;
    logic            take_redirect;
    logic            misaligned;

    keen_pc_next #(
        .XLEN (XLEN),
        .ILEN (ILEN)
    ) u_next (
        .state           (state),
        .pc              (pc),
        .pc_ready        (pc_ready),
        .branch          (branch),
        .branch_address  (branch_address),
        .trap            (trap),
        .trap_vector     (trap_vector),
`ifdef KEEN_PC_COMPRESSED_EN
        .inst_compressed (inst_compressed),
`endif
        .next_pc         (next_pc),
        .take_redirect   (take_redirect),
        .misaligned      (misaligned)
    );

    // State, pc and fault registers. pc_valid is registered alongside the
    // state so it reflects the state being entered, not the one being left.
    // The fault pulse lasts one cycle because misaligned can only be raised
    // from RUN, and the unit leaves RUN on that same edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= BOOT;
            pc            <= RESET_VECTOR;
            pc_valid      <= 1'b0;
            fault_valid   <= 1'b0;
            fault_address <= '0;
        end else begin
            pc          <= next_pc;
            fault_valid <= misaligned;
            if (misaligned) begin
                fault_address <= branch_address;
            end
            case (state)
                BOOT: begin
                    state    <= RUN;
                    pc_valid <= 1'b1;
                end
                RUN: begin
                    if (misaligned) begin
                        state    <= FAULT;
                        pc_valid <= 1'b0;
                    end
                end
                FAULT: begin
                    if (take_redirect) begin
                        state    <= RUN;
                        pc_valid <= 1'b1;
                    end
                end
                default: begin
                    state    <= BOOT;
                    pc_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
